// File: rtl/cpu_memory_ctl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_memory_pkg : shared types and constants for cpu_memory_ctl       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package cpu_memory_pkg;

  typedef enum logic [1:0] {
    ST_FONT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam int unsigned FONT_BYTES       = 80;
  localparam int unsigned CLR_BASE_DEFAULT = 'h200;

endpackage
`default_nettype wire

// File: rtl/cpu_memory_ctl_font_rom.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chip8_font_rom : 80-byte hex digit font (0-F, 5 rows per glyph)      |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module chip8_font_rom (
  input  logic [6:0] idx,
  output logic [7:0] data
);

  always_comb begin
    data = 8'h00;
    case (idx)
      7'd0:  data = 8'hF0; 7'd1:  data = 8'h90; 7'd2:  data = 8'h90; 7'd3:  data = 8'h90; 7'd4:  data = 8'hF0;
      7'd5:  data = 8'h20; 7'd6:  data = 8'h60; 7'd7:  data = 8'h20; 7'd8:  data = 8'h20; 7'd9:  data = 8'h70;
      7'd10: data = 8'hF0; 7'd11: data = 8'h10; 7'd12: data = 8'hF0; 7'd13: data = 8'h80; 7'd14: data = 8'hF0;
      7'd15: data = 8'hF0; 7'd16: data = 8'h10; 7'd17: data = 8'hF0; 7'd18: data = 8'h10; 7'd19: data = 8'hF0;
      7'd20: data = 8'h90; 7'd21: data = 8'h90; 7'd22: data = 8'hF0; 7'd23: data = 8'h10; 7'd24: data = 8'h10;
      7'd25: data = 8'hF0; 7'd26: data = 8'h80; 7'd27: data = 8'hF0; 7'd28: data = 8'h10; 7'd29: data = 8'hF0;
      7'd30: data = 8'hF0; 7'd31: data = 8'h80; 7'd32: data = 8'hF0; 7'd33: data = 8'h90; 7'd34: data = 8'hF0;
      7'd35: data = 8'hF0; 7'd36: data = 8'h10; 7'd37: data = 8'h20; 7'd38: data = 8'h40; 7'd39: data = 8'h40;
      7'd40: data = 8'hF0; 7'd41: data = 8'h90; 7'd42: data = 8'hF0; 7'd43: data = 8'h90; 7'd44: data = 8'hF0;
      7'd45: data = 8'hF0; 7'd46: data = 8'h90; 7'd47: data = 8'hF0; 7'd48: data = 8'h10; 7'd49: data = 8'hF0;
      7'd50: data = 8'hF0; 7'd51: data = 8'h90; 7'd52: data = 8'hF0; 7'd53: data = 8'h90; 7'd54: data = 8'h90;
      7'd55: data = 8'hE0; 7'd56: data = 8'h90; 7'd57: data = 8'hE0; 7'd58: data = 8'h90; 7'd59: data = 8'hE0;
      7'd60: data = 8'hF0; 7'd61: data = 8'h80; 7'd62: data = 8'h80; 7'd63: data = 8'h80; 7'd64: data = 8'hF0;
      7'd65: data = 8'hE0; 7'd66: data = 8'h90; 7'd67: data = 8'h90; 7'd68: data = 8'h90; 7'd69: data = 8'hE0;
      7'd70: data = 8'hF0; 7'd71: data = 8'h80; 7'd72: data = 8'hF0; 7'd73: data = 8'h80; 7'd74: data = 8'hF0;
      7'd75: data = 8'hF0; 7'd76: data = 8'h80; 7'd77: data = 8'hF0; 7'd78: data = 8'h80; 7'd79: data = 8'h80;
      default: data = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_memory_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_memory_ctl : dual-port CPU memory with font/clear init sequencer |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module cpu_memory_ctl
  import cpu_memory_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned FONT_BASE      = 0,
  parameter int unsigned CLR_BASE       = CLR_BASE_DEFAULT,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_in,
  output logic              a_ready,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_out,
  output logic              b_valid,
  input  logic              clr_start,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       DEPTH         = 2**ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE       = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_LAST      = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0]   CNT_CLR       = (ADDR_W+1)'(CLR_BASE);
  localparam logic [ADDR_W:0]   CNT_FONT_LAST = (ADDR_W+1)'(FONT_BYTES-1);
  localparam logic [ADDR_W-1:0] FONT_ADDR     = ADDR_W'(FONT_BASE);

  if (FONT_BASE + FONT_BYTES > CLR_BASE) begin : g_bad_layout
    $error("cpu_memory_ctl: font image overlaps the clear range");
  end

  state_t              r_state;
  logic [ADDR_W:0]     r_cnt;
  logic                r_busy;
  logic                r_ready;
  logic                r_done;
  logic [7:0]          w_font_byte;
  logic                w_a_acc;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   r_a_q1;
  logic [DATA_W-1:0]   r_b_q1;
  logic                r_a_v1;
  logic                r_b_v1;

  chip8_font_rom u_font (
    .idx  (r_cnt[6:0]),
    .data (w_font_byte)
  );

  // Counter is one bit wider than the address so reaching DEPTH-1 never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FONT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_FONT: begin
          if (r_cnt == CNT_FONT_LAST) begin
            if (CLEAR_ON_RESET) begin
              r_state <= ST_CLEAR;
              r_cnt   <= CNT_CLR;
            end else begin
              r_state <= ST_READY;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_CLEAR: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_READY: begin
          if (clr_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= CNT_CLR;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_FONT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign w_a_acc = a_en & r_ready;

  always_comb begin
    w_we    = w_a_acc & a_write;
    w_waddr = a_addr;
    w_wdata = a_in;
    if (r_state == ST_FONT) begin
      w_we    = 1'b1;
      w_waddr = FONT_ADDR + r_cnt[ADDR_W-1:0];
      w_wdata = DATA_W'(w_font_byte);
    end else if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_cnt[ADDR_W-1:0];
      w_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) mem[w_waddr] <= w_wdata;
  end

  // Reads sample the array before this edge's write lands, so B sees old data on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_q1 <= '0;
      r_a_v1 <= 1'b0;
      r_b_q1 <= '0;
      r_b_v1 <= 1'b0;
    end else begin
      r_a_v1 <= w_a_acc;
      r_b_v1 <= b_en;
      if (w_a_acc) r_a_q1 <= a_write ? a_in : mem[a_addr];
      if (b_en)    r_b_q1 <= mem[b_addr];
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] r_a_q2;
    logic [DATA_W-1:0] r_b_q2;
    logic              r_a_v2;
    logic              r_b_v2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_a_q2 <= '0;
        r_a_v2 <= 1'b0;
        r_b_q2 <= '0;
        r_b_v2 <= 1'b0;
      end else begin
        r_a_v2 <= r_a_v1;
        r_b_v2 <= r_b_v1;
        if (r_a_v1) r_a_q2 <= r_a_q1;
        if (r_b_v1) r_b_q2 <= r_b_q1;
      end
    end

    assign a_out   = r_a_q2;
    assign a_valid = r_a_v2;
    assign b_out   = r_b_q2;
    assign b_valid = r_b_v2;
  end else begin : g_lat1
    assign a_out   = r_a_q1;
    assign a_valid = r_a_v1;
    assign b_out   = r_b_q1;
    assign b_valid = r_b_v1;
  end

  assign a_ready = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_memory_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cpu_memory_ctl : directed self-checking bench for cpu_memory_ctl  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_cpu_memory_ctl;

  logic        clk = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  // u_dut: defaults (RD_LAT=1, CLEAR_ON_RESET=1)
  logic        rst, a_en, a_write, b_en, clr_start;
  logic [11:0] a_addr, b_addr;
  logic [7:0]  a_in, a_out, b_out;
  logic        a_ready, a_valid, b_valid, busy, done;

  // u_dut2: RD_LAT=2, CLEAR_ON_RESET=0
  logic        rst2, a_en2, a_write2, b_en2, clr_start2;
  logic [11:0] a_addr2, b_addr2;
  logic [7:0]  a_in2, a_out2, b_out2;
  logic        a_ready2, a_valid2, b_valid2, busy2, done2;

  always #5 clk = ~clk;

  cpu_memory_ctl u_dut (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_write(a_write), .a_addr(a_addr), .a_in(a_in),
    .a_ready(a_ready), .a_out(a_out), .a_valid(a_valid),
    .b_en(b_en), .b_addr(b_addr), .b_out(b_out), .b_valid(b_valid),
    .clr_start(clr_start), .busy(busy), .done(done)
  );

  cpu_memory_ctl #(.RD_LAT(2), .CLEAR_ON_RESET(1'b0)) u_dut2 (
    .clk(clk), .rst(rst2),
    .a_en(a_en2), .a_write(a_write2), .a_addr(a_addr2), .a_in(a_in2),
    .a_ready(a_ready2), .a_out(a_out2), .a_valid(a_valid2),
    .b_en(b_en2), .b_addr(b_addr2), .b_out(b_out2), .b_valid(b_valid2),
    .clr_start(clr_start2), .busy(busy2), .done(done2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rst2 = 1'b0;
    a_en = 0; a_write = 0; a_addr = '0; a_in = '0; b_en = 0; b_addr = '0; clr_start = 0;
    a_en2 = 0; a_write2 = 0; a_addr2 = '0; a_in2 = '0; b_en2 = 0; b_addr2 = '0; clr_start2 = 0;
    #2;
    rst = 1'b1; rst2 = 1'b1;
    tick; tick;
    vectors++;
    if ({a_ready, busy, done, a_valid, b_valid, a_out, b_out} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_dut: got ready=%b busy=%b done=%b av=%b bv=%b a_out=%h b_out=%h expected 0 1 0 0 0 00 00",
               a_ready, busy, done, a_valid, b_valid, a_out, b_out);
    end
    vectors++;
    if ({a_ready2, busy2, done2, a_valid2, b_valid2, a_out2, b_out2} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_dut2: got ready=%b busy=%b done=%b av=%b bv=%b a_out=%h b_out=%h expected 0 1 0 0 0 00 00",
               a_ready2, busy2, done2, a_valid2, b_valid2, a_out2, b_out2);
    end
    rst = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_init;
    int first_done = 0, done_cnt = 0, first_done2 = 0, done_cnt2 = 0;
    for (int n = 1; n <= 3670; n++) begin
      tick;
      if (done)  begin done_cnt++;  if (first_done == 0)  first_done = n;  end
      if (done2) begin done_cnt2++; if (first_done2 == 0) first_done2 = n; end
      if (n == 3663) begin
        vectors++;
        if (busy !== 1'b1 || a_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL init_busy_end: got busy=%b ready=%b expected 1 0", busy, a_ready);
        end
      end
      if (n == 3664) begin
        vectors++;
        if (busy !== 1'b0 || a_ready !== 1'b1 || done !== 1'b1) begin
          miscompares++;
          $display("FAIL init_ready: got busy=%b ready=%b done=%b expected 0 1 1", busy, a_ready, done);
        end
      end
      if (n == 11) begin
        vectors++;
        if (b_valid2 !== 1'b0) begin
          miscompares++;
          $display("FAIL dut2_b_lat_early: got b_valid=%b expected 0", b_valid2);
        end
      end
      if (n == 12) begin
        vectors++;
        if (b_valid2 !== 1'b1 || b_out2 !== 8'hF0) begin
          miscompares++;
          $display("FAIL dut2_b_during_font: got valid=%b data=%h expected 1 f0", b_valid2, b_out2);
        end
      end
      if (n == 80) begin
        vectors++;
        if (a_ready2 !== 1'b1 || busy2 !== 1'b0) begin
          miscompares++;
          $display("FAIL dut2_ready: got ready=%b busy=%b expected 1 0", a_ready2, busy2);
        end
      end
      b_en2   = (n == 10);
      b_addr2 = 12'h000;
    end
    vectors++;
    if (first_done !== 3664 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL init_done: got cycle=%0d pulses=%0d expected 3664 1", first_done, done_cnt);
    end
    vectors++;
    if (first_done2 !== 80 || done_cnt2 !== 1) begin
      miscompares++;
      $display("FAIL dut2_init_done: got cycle=%0d pulses=%0d expected 80 1", first_done2, done_cnt2);
    end
  endtask

  task automatic test_port_a_read;
    logic [11:0] addrs [6];
    logic [7:0]  exps  [6];
    addrs = '{12'h000, 12'h005, 12'h037, 12'h04F, 12'h200, 12'hFFF};
    exps  = '{8'hF0,   8'h20,   8'hE0,   8'h80,   8'h00,   8'h00};
    for (int i = 0; i < 6; i++) begin
      a_en = 1'b1; a_write = 1'b0; a_addr = addrs[i];
      tick;
      a_en = 1'b0;
      vectors++;
      if (a_valid !== 1'b1 || a_out !== exps[i]) begin
        miscompares++;
        $display("FAIL port_a_read[%h]: got valid=%b data=%h expected 1 %h", addrs[i], a_valid, a_out, exps[i]);
      end
      tick;
      vectors++;
      if (a_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL port_a_valid_pulse[%h]: got %b expected 0", addrs[i], a_valid);
      end
    end
  endtask

  task automatic test_rd_lat2;
    logic [11:0] addrs [3];
    logic [7:0]  exps  [3];
    logic        wr    [3];
    addrs = '{12'h300, 12'h04F, 12'h300};
    exps  = '{8'h5A,   8'h80,   8'h5A};
    wr    = '{1'b1,    1'b0,    1'b0};
    for (int i = 0; i < 3; i++) begin
      a_en2 = 1'b1; a_write2 = wr[i]; a_addr2 = addrs[i]; a_in2 = 8'h5A;
      tick;
      a_en2 = 1'b0; a_write2 = 1'b0;
      vectors++;
      if (a_valid2 !== 1'b0) begin
        miscompares++;
        $display("FAIL lat2_early[%0d]: got valid=%b expected 0", i, a_valid2);
      end
      tick;
      vectors++;
      if (a_valid2 !== 1'b1 || a_out2 !== exps[i]) begin
        miscompares++;
        $display("FAIL lat2_data[%0d]: got valid=%b data=%h expected 1 %h", i, a_valid2, a_out2, exps[i]);
      end
      tick;
      vectors++;
      if (a_valid2 !== 1'b0 || a_out2 !== exps[i]) begin
        miscompares++;
        $display("FAIL lat2_hold[%0d]: got valid=%b data=%h expected 0 %h", i, a_valid2, a_out2, exps[i]);
      end
    end
  endtask

  task automatic test_collision;
    a_en = 1'b1; a_write = 1'b1; a_addr = 12'h250; a_in = 8'h11;
    tick;
    a_in = 8'hAA; b_en = 1'b1; b_addr = 12'h250;
    tick;
    a_en = 1'b0; a_write = 1'b0; b_en = 1'b0;
    vectors++;
    if (b_valid !== 1'b1 || b_out !== 8'h11) begin
      miscompares++;
      $display("FAIL collision_b_old: got valid=%b data=%h expected 1 11", b_valid, b_out);
    end
    vectors++;
    if (a_valid !== 1'b1 || a_out !== 8'hAA) begin
      miscompares++;
      $display("FAIL collision_a_wfirst: got valid=%b data=%h expected 1 aa", a_valid, a_out);
    end
    b_en = 1'b1;
    tick;
    b_en = 1'b0;
    vectors++;
    if (b_valid !== 1'b1 || b_out !== 8'hAA) begin
      miscompares++;
      $display("FAIL collision_b_new: got valid=%b data=%h expected 1 aa", b_valid, b_out);
    end
    tick;
    vectors++;
    if (b_valid !== 1'b0 || b_out !== 8'hAA) begin
      miscompares++;
      $display("FAIL b_hold: got valid=%b data=%h expected 0 aa", b_valid, b_out);
    end
  endtask

  task automatic test_clear;
    logic [11:0] addrs [3];
    logic [7:0]  pre   [3];
    logic [7:0]  post  [3];
    int first_done = 0, done_cnt = 0, av_cnt = 0;
    addrs = '{12'h200, 12'hFFF, 12'h010};
    pre   = '{8'h12,   8'h34,   8'h77};
    post  = '{8'h00,   8'h00,   8'h77};
    for (int i = 0; i < 3; i++) begin
      a_en = 1'b1; a_write = 1'b1; a_addr = addrs[i]; a_in = pre[i];
      tick;
    end
    a_en = 1'b0; a_write = 1'b0;
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || a_ready !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_start: got busy=%b ready=%b done=%b expected 1 0 0", busy, a_ready, done);
    end
    for (int n = 1; n <= 3600; n++) begin
      a_en = (n == 5); a_write = 1'b1; a_addr = 12'h010; a_in = 8'h99;
      clr_start = (n == 10);
      tick;
      if (a_valid) av_cnt++;
      if (done) begin done_cnt++; if (first_done == 0) first_done = n; end
      if (n == 3583) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL clear_busy_end: got busy=%b expected 1", busy);
        end
      end
      if (n == 3584) begin
        vectors++;
        if (busy !== 1'b0 || a_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL clear_ready: got busy=%b ready=%b expected 0 1", busy, a_ready);
        end
      end
    end
    a_en = 1'b0; a_write = 1'b0; clr_start = 1'b0;
    vectors++;
    if (first_done !== 3584 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL clear_done: got cycle=%0d pulses=%0d expected 3584 1", first_done, done_cnt);
    end
    vectors++;
    if (av_cnt !== 0) begin
      miscompares++;
      $display("FAIL clear_drop_a: got a_valid pulses=%0d expected 0", av_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      a_en = 1'b1; a_addr = addrs[i];
      tick;
      a_en = 1'b0;
      vectors++;
      if (a_valid !== 1'b1 || a_out !== post[i]) begin
        miscompares++;
        $display("FAIL clear_result[%h]: got valid=%b data=%h expected 1 %h", addrs[i], a_valid, a_out, post[i]);
      end
    end
  endtask

  task automatic test_reset_mid_init;
    int first_done = 0, done_cnt = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({a_ready, busy, done, a_valid, a_out} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL async_reset: got ready=%b busy=%b done=%b av=%b a_out=%h expected 0 1 0 0 00",
               a_ready, busy, done, a_valid, a_out);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      tick;
      b_en = (n == 999); b_addr = 12'h000;
    end
    b_en = 1'b0;
    vectors++;
    if (busy !== 1'b1 || b_valid !== 1'b1 || b_out !== 8'hF0) begin
      miscompares++;
      $display("FAIL mid_init_state: got busy=%b bv=%b b_out=%h expected 1 1 f0", busy, b_valid, b_out);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({a_ready, busy, done, b_valid, b_out} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL mid_init_reset: got ready=%b busy=%b done=%b bv=%b b_out=%h expected 0 1 0 0 00",
               a_ready, busy, done, b_valid, b_out);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 1; n <= 3670; n++) begin
      tick;
      if (done) begin done_cnt++; if (first_done == 0) first_done = n; end
    end
    vectors++;
    if (first_done !== 3664 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL reinit_done: got cycle=%0d pulses=%0d expected 3664 1", first_done, done_cnt);
    end
    a_en = 1'b1; a_write = 1'b0; a_addr = 12'h250;
    tick;
    a_en = 1'b0;
    vectors++;
    if (a_valid !== 1'b1 || a_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reinit_cleared: got valid=%b data=%h expected 1 00", a_valid, a_out);
    end
    a_en = 1'b1; a_addr = 12'h04A;
    tick;
    a_en = 1'b0;
    vectors++;
    if (a_valid !== 1'b1 || a_out !== 8'hF0) begin
      miscompares++;
      $display("FAIL reinit_font: got valid=%b data=%h expected 1 f0", a_valid, a_out);
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_port_a_read;
    test_rd_lat2;
    test_collision;
    test_clear;
    test_reset_mid_init;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
